// File: rtl/apb_gpio_slave.sv
// APB3 completer for a 32-bit GPIO bank: register file, pin synchroniser,
// rising-edge interrupt capture and programmable access wait states.
module apb_gpio_slave #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    inout  wire  [31:0]       gpioIO,
    output logic              irq
);
    localparam int IW = ADDR_W - 2;
    localparam int CW = 4;
    localparam logic [CW-1:0] WS = CW'(WAIT_STATES);
    localparam logic [IW-1:0] A_DOUT = IW'(0);
    localparam logic [IW-1:0] A_DIR  = IW'(1);
    localparam logic [IW-1:0] A_DIN  = IW'(2);
    localparam logic [IW-1:0] A_IEN  = IW'(3);
    localparam logic [IW-1:0] A_STAT = IW'(4);
    localparam logic [IW-1:0] A_SET  = IW'(5);
    localparam logic [IW-1:0] A_CLR  = IW'(6);

    // The setup phase is recognised on the edge that closes it, so ACCESS
    // is entered with PREADY already resolved for the first access cycle.
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   dout;
    logic [31:0]   dir;
    logic [31:0]   ien;
    logic [31:0]   status;
    logic [31:0]   sync_q [SYNC_STAGES];
    logic [31:0]   din;
    logic [31:0]   din_q;
    logic [31:0]   dir_nxt;
    logic [31:0]   rise;
    logic [31:0]   rd_mux;
    logic [IW-1:0] idx;
    logic          hit_dout, hit_dir, hit_din, hit_ien;
    logic          hit_stat, hit_set, hit_clr;
    logic          bad;
    logic          start;
    logic          commit;
    logic          load;
    logic          do_write;
    logic          unused_bits;

    assign idx         = PADDR[ADDR_W-1:2];
    assign unused_bits = ^PADDR[1:0];
    assign hit_dout    = idx == A_DOUT;
    assign hit_dir     = idx == A_DIR;
    assign hit_din     = idx == A_DIN;
    assign hit_ien     = idx == A_IEN;
    assign hit_stat    = idx == A_STAT;
    assign hit_set     = idx == A_SET;
    assign hit_clr     = idx == A_CLR;
    assign din         = sync_q[SYNC_STAGES-1];

    always_comb begin
        rd_mux = '0;
        bad    = 1'b0;
        unique case (1'b1)
            hit_dout:         rd_mux = dout;
            hit_dir:          rd_mux = dir;
            hit_din:          rd_mux = din;
            hit_ien:          rd_mux = ien;
            hit_stat:         rd_mux = status;
            hit_set, hit_clr: rd_mux = '0;
            default:          bad    = 1'b1;
        endcase
        if (PWRITE && hit_din) bad = 1'b1;
        if (PWRITE || bad) rd_mux = '0;
    end

    always_comb begin
        start    = (state == IDLE) && PSEL && !PENABLE;
        commit   = (state == ACCESS) && PSEL && PENABLE && PREADY;
        load     = (start && WS == '0) ||
                   ((state == ACCESS) && PSEL && !PREADY &&
                    (cnt + 1'b1) == WS);
        do_write = commit && PWRITE && !bad;
        dir_nxt  = (do_write && hit_dir) ? PWDATA : dir;
        // A bit turning into an output this cycle must not raise an event.
        rise     = din & ~din_q & ~dir & ~dir_nxt;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCESS;
                        cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (!PSEL || commit) begin
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PRDATA  <= '0;
                        PSLVERR <= 1'b0;
                    end else if (!PREADY) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
            if (load) begin
                PREADY  <= 1'b1;
                PRDATA  <= rd_mux;
                PSLVERR <= bad;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            dout   <= '0;
            dir    <= '0;
            ien    <= '0;
            status <= '0;
            din_q  <= '0;
            irq    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            if (do_write) begin
                unique case (1'b1)
                    hit_dout: dout <= PWDATA;
                    hit_set:  dout <= dout | PWDATA;
                    hit_clr:  dout <= dout & ~PWDATA;
                    hit_dir:  dir  <= PWDATA;
                    hit_ien:  ien  <= PWDATA;
                    default:  ;
                endcase
            end
            // New edges are ORed in after the clear, so set wins.
            status <= (status & ~((do_write && hit_stat) ? PWDATA : '0)) |
                      rise;
            irq    <= |(status & ien);
            din_q  <= din;
            sync_q[0] <= gpioIO;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_pin
        assign gpioIO[i] = dir[i] ? dout[i] : 1'bz;
    end
endmodule
